// File: rtl/alu_pkg.sv
// Shared op-code constants and FSM state encoding for the multi-cycle ALU.
package alu_pkg;

    // Math group (alu_sel = 0)
    localparam int unsigned OP_ADD  = 0;
    localparam int unsigned OP_SUB  = 1;
    localparam int unsigned OP_MUL  = 2;
    localparam int unsigned OP_DIVU = 3;
    localparam int unsigned OP_REMU = 4;
    localparam int unsigned OP_SLT  = 5;
    localparam int unsigned OP_SLTU = 6;

    // Logic group (alu_sel = 1)
    localparam int unsigned LOP_AND = 0;
    localparam int unsigned LOP_OR  = 1;
    localparam int unsigned LOP_XOR = 2;
    localparam int unsigned LOP_NOT = 3;
    localparam int unsigned LOP_SLL = 4;
    localparam int unsigned LOP_SRL = 5;
    localparam int unsigned LOP_SRA = 6;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic             run_q;
    logic             is_mul_q;
    logic             is_rem_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opnd_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;

    // hi/lo hold {accumulator, multiplier} for MUL and {remainder, quotient} for DIV/REM.
    always_comb begin
        mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : {WIDTH{1'b0}})};
        shifted = {hi_q, lo_q[WIDTH-1]};
        ge      = shifted >= {1'b0, opnd_q};
        diff    = shifted[WIDTH-1:0] - opnd_q;
        if (is_mul_q) begin
            hi_n = mul_sum[WIDTH:1];
            lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else begin
            hi_n = ge ? diff : shifted[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], ge};
        end
    end

    // Outputs reflect the final iteration combinationally so the FSM can load them on that edge.
    assign done   = run_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign result = is_rem_q ? hi_n : lo_n;
    assign flag   = is_mul_q && (|hi_n);

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q    <= 1'b0;
            is_mul_q <= 1'b0;
            is_rem_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            run_q    <= 1'b1;
            is_mul_q <= (op == OP_W'(OP_MUL));
            is_rem_q <= (op == OP_W'(OP_REMU));
            hi_q     <= '0;
            lo_q     <= a;
            opnd_q   <= b;
            cnt_q    <= '0;
        end else if (run_q) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q + CNT_W'(1);
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc_top.sv
// Multi-cycle ALU: single-cycle math/logic ops plus iterative MUL/DIVU/REMU behind a
// valid/ready request and result handshake.
module alu_mc_top
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [OP_W-1:0]  alu_op,
    input  logic             alu_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             flag,
    output logic             busy
);

    localparam int unsigned SH_W = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             flag_q, flag_d;

    logic             accept;
    logic             is_multi;
    logic [WIDTH-1:0] sc_res;
    logic             sc_flag;
    logic [WIDTH:0]   add_full;
    logic [SH_W-1:0]  shamt;

    logic             md_done;
    logic [WIDTH-1:0] md_res;
    logic             md_flag;

    assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state_q == ST_DONE);
    assign busy       = (state_q == ST_CALC);
    assign alu_result = res_q;
    assign flag       = flag_q;

    // Divide by zero is resolved in one cycle, so only a nonzero divisor goes iterative.
    assign is_multi = !alu_sel && ((alu_op == OP_W'(OP_MUL)) ||
                      (((alu_op == OP_W'(OP_DIVU)) || (alu_op == OP_W'(OP_REMU))) &&
                       (alu_b != '0)));

    always_comb begin
        sc_res   = '0;
        sc_flag  = 1'b0;
        add_full = {1'b0, alu_a} + {1'b0, alu_b};
        shamt    = alu_b[SH_W-1:0];
        if (!alu_sel) begin
            case (alu_op)
                OP_W'(OP_ADD): begin
                    sc_res  = add_full[WIDTH-1:0];
                    sc_flag = add_full[WIDTH];
                end
                OP_W'(OP_SUB): begin
                    sc_res  = alu_a - alu_b;
                    sc_flag = alu_a < alu_b;
                end
                OP_W'(OP_DIVU): begin
                    sc_res  = '1;
                    sc_flag = 1'b1;
                end
                OP_W'(OP_REMU): begin
                    sc_res  = alu_a;
                    sc_flag = 1'b1;
                end
                OP_W'(OP_SLT):  sc_res = WIDTH'($signed(alu_a) < $signed(alu_b));
                OP_W'(OP_SLTU): sc_res = WIDTH'(alu_a < alu_b);
                default:        sc_res = '0;
            endcase
        end else begin
            case (alu_op)
                OP_W'(LOP_AND): sc_res = alu_a & alu_b;
                OP_W'(LOP_OR):  sc_res = alu_a | alu_b;
                OP_W'(LOP_XOR): sc_res = alu_a ^ alu_b;
                OP_W'(LOP_NOT): sc_res = ~alu_a;
                OP_W'(LOP_SLL): sc_res = alu_a << shamt;
                OP_W'(LOP_SRL): sc_res = alu_a >> shamt;
                OP_W'(LOP_SRA): sc_res = $unsigned($signed(alu_a) >>> shamt);
                default:        sc_res = '0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        flag_d  = flag_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if ((state_q == ST_DONE) && out_ready) begin
                    state_d = ST_IDLE;
                end
                if (accept) begin
                    if (is_multi) begin
                        state_d = ST_CALC;
                    end else begin
                        state_d = ST_DONE;
                        res_d   = sc_res;
                        flag_d  = sc_flag;
                    end
                end
            end
            ST_CALC: begin
                if (md_done) begin
                    state_d = ST_DONE;
                    res_d   = md_res;
                    flag_d  = md_flag;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            flag_q  <= flag_d;
        end
    end

    alu_muldiv #(
        .WIDTH (WIDTH),
        .OP_W  (OP_W)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && is_multi),
        .op     (alu_op),
        .a      (alu_a),
        .b      (alu_b),
        .done   (md_done),
        .result (md_res),
        .flag   (md_flag)
    );

endmodule

// File: tb/tb_alu_mc_top.sv
// Randomized self-checking bench for alu_mc_top at WIDTH=32 with a small WIDTH=8 instance.
module tb_alu_mc_top;

    logic        clk;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready, alu_sel, flag, busy;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [4:0]  alu_op;

    logic        e_in_valid, e_in_ready, e_out_valid, e_out_ready, e_alu_sel, e_flag, e_busy;
    logic [7:0]  e_alu_a, e_alu_b, e_alu_result;
    logic [4:0]  e_alu_op;

    int n_vec;
    int n_err;

    alu_mc_top #(.WIDTH(32), .OP_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_sel    (alu_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .flag       (flag),
        .busy       (busy)
    );

    alu_mc_top #(.WIDTH(8), .OP_W(5)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (e_in_valid),
        .in_ready   (e_in_ready),
        .alu_a      (e_alu_a),
        .alu_b      (e_alu_b),
        .alu_op     (e_alu_op),
        .alu_sel    (e_alu_sel),
        .out_valid  (e_out_valid),
        .out_ready  (e_out_ready),
        .alu_result (e_alu_result),
        .flag       (e_flag),
        .busy       (e_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on 64/128-bit values, truncated to w bits. Returns {flag, result}.
    function automatic logic [64:0] ref_alu(input int w, input int op, input bit sel,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [63:0]  mask;
        logic [127:0] p;
        logic [63:0]  r;
        bit           f;
        longint       sa, sb;
        int           sh;
        mask = (64'd1 << w) - 64'd1;
        r    = 0;
        f    = 0;
        sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        sh   = int'(b[7:0]) % w;
        if (!sel) begin
            case (op)
                0: begin p = a + b; r = p[63:0]; f = p[w]; end
                1: begin r = a - b; f = (a < b); end
                2: begin p = a * b; r = p[63:0]; f = ((p >> w) != 0); end
                3: if (b == 0) begin r = mask; f = 1; end else r = a / b;
                4: if (b == 0) begin r = a; f = 1; end else r = a % b;
                5: r = (sa < sb) ? 1 : 0;
                6: r = (a < b) ? 1 : 0;
                default: r = 0;
            endcase
        end else begin
            case (op)
                0: r = a & b;
                1: r = a | b;
                2: r = a ^ b;
                3: r = ~a;
                4: r = a << sh;
                5: r = a >> sh;
                6: r = 64'(sa >>> sh);
                default: r = 0;
            endcase
        end
        return {f, r & mask};
    endfunction

    function automatic bit is_iter(input int op, input bit sel, input logic [63:0] b);
        return !sel && (op == 2 || ((op == 3 || op == 4) && b != 0));
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                         input bit sel, input int hold);
        logic [64:0] exp;
        int          lat, nbusy;
        bit          multi;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        alu_a = a; alu_b = b; alu_op = op; alu_sel = sel;
        in_valid = 1; out_ready = 0;
        exp   = ref_alu(32, int'(op), sel, 64'(a), 64'(b));
        multi = is_iter(int'(op), sel, 64'(b));
        @(negedge clk);
        in_valid = 0;
        // Operands must be ignored once captured
        alu_a = $urandom; alu_b = $urandom; alu_op = 5'($urandom); alu_sel = 1'($urandom);
        lat = 1; nbusy = 0;
        while (!out_valid && lat < 100) begin
            if (busy) nbusy++;
            if (in_ready) nbusy += 1000;
            @(negedge clk);
            lat++;
        end
        check("latency", lat, multi ? 33 : 1);
        check("busy_cycles", nbusy, multi ? 32 : 0);
        check("result", alu_result, exp[31:0]);
        check("flag", flag, exp[64]);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_result", {flag, alu_result}, {exp[64], exp[31:0]});
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        check("drop_valid", out_valid, 0);
        check("retain_result", {flag, alu_result}, {exp[64], exp[31:0]});
    endtask

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic [4:0] op,
                          input bit sel);
        logic [64:0] exp;
        int          lat;
        @(negedge clk);
        e_alu_a = a; e_alu_b = b; e_alu_op = op; e_alu_sel = sel;
        e_in_valid = 1; e_out_ready = 0;
        exp = ref_alu(8, int'(op), sel, 64'(a), 64'(b));
        @(negedge clk);
        e_in_valid = 0;
        lat = 1;
        while (!e_out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("w8_latency", lat, is_iter(int'(op), sel, 64'(b)) ? 9 : 1);
        check("w8_result", e_alu_result, exp[7:0]);
        check("w8_flag", e_flag, exp[64]);
        e_out_ready = 1;
        @(negedge clk);
        e_out_ready = 0;
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 3))
            0:       return 32'h0;
            1:       return 32'($urandom_range(0, 40));
            2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1;
        in_valid = 0; out_ready = 0; alu_a = 0; alu_b = 0; alu_op = 0; alu_sel = 0;
        e_in_valid = 0; e_out_ready = 0; e_alu_a = 0; e_alu_b = 0; e_alu_op = 0; e_alu_sel = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", alu_result, 0);
        check("rst_flag", flag, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_w8_in_ready", e_in_ready, 1);

        do_op(32'hFFFF_FFFF, 32'h1, 5'd0, 0, 1);        // ADD carry
        do_op(32'h0001_0000, 32'h0001_0000, 5'd2, 0, 0); // MUL overflow
        do_op(32'd100, 32'd7, 5'd3, 0, 0);              // DIVU
        do_op(32'd100, 32'd7, 5'd4, 0, 0);              // REMU
        do_op(32'd100, 32'd0, 5'd3, 0, 0);              // DIVU by zero
        do_op(32'd55, 32'd0, 5'd4, 0, 0);               // REMU by zero
        do_op(32'h8000_0000, 32'd4, 5'd6, 1, 0);        // SRA
        do_op(32'h1234_5678, 32'h9ABC_DEF0, 5'd9, 1, 0); // undefined logic op
        do_op(32'h1234_5678, 32'h9ABC_DEF0, 5'd9, 0, 0); // undefined math op

        // Backpressure, then back-to-back accept from DONE
        @(negedge clk);
        alu_a = 32'd3; alu_b = 32'd5; alu_op = 5'd1; alu_sel = 0; in_valid = 1; out_ready = 0;
        @(negedge clk);
        in_valid = 0;
        check("bp_valid", out_valid, 1);
        check("bp_result", alu_result, 32'hFFFF_FFFE);
        check("bp_flag", flag, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {flag, alu_result}, {1'b1, 32'hFFFF_FFFE});
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1; in_valid = 1;
        alu_a = 32'd7; alu_b = 32'd8; alu_op = 5'd0;
        #1;
        check("b2b_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 0; out_ready = 0;
        check("b2b_valid", out_valid, 1);
        check("b2b_result", alu_result, 32'd15);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;

        // Reset in the middle of a divide
        @(negedge clk);
        alu_a = 32'd100; alu_b = 32'd7; alu_op = 5'd3; alu_sel = 0; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (9) @(negedge clk);
        check("calc10_busy", busy, 1);
        rst = 1;
        @(negedge clk);
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_result", alu_result, 0);
        check("abort_in_ready", in_ready, 1);
        rst = 0;
        repeat (40) @(negedge clk);
        check("abort_no_late_result", out_valid, 0);
        do_op(32'd2, 32'd2, 5'd0, 0, 0);

        for (int i = 0; i < 120; i++) begin
            logic [4:0] op;
            op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(7, 31)) : 5'($urandom_range(0, 6));
            do_op(rand_opnd(), rand_opnd(), op, 1'($urandom), $urandom_range(0, 2));
        end

        do_op8(8'hFF, 8'h01, 5'd5, 0);                  // SLT -1 < 1
        do_op8(8'hFF, 8'h01, 5'd6, 0);                  // SLTU 255 < 1
        for (int i = 0; i < 30; i++) begin
            do_op8(8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                   5'($urandom_range(0, 7)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
